// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: state encoding, default
// memory geometry and the byte stride between consecutive 32-bit words.
package mem_copy_engine_pkg;

  localparam int DEF_RAM_SIZE     = 256;
  localparam int DEF_RAM_SIZE_BIT = 8;
  localparam int WORD_STRIDE      = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/mem_copy_range_check.sv
// Combinational request validation: word alignment of both pointers and
// range end (addr + 4*count) within the data memory.
module mem_copy_range_check
  import mem_copy_engine_pkg::*;
#(
  parameter int RAM_SIZE     = DEF_RAM_SIZE,
  parameter int RAM_SIZE_BIT = DEF_RAM_SIZE_BIT
) (
  input  logic [31:0]           i_src_addr,
  input  logic [31:0]           i_dst_addr,
  input  logic [RAM_SIZE_BIT:0] i_word_count,
  input  logic                  i_check_src,
  output logic                  o_valid
);

  // 34 bits keep addr + span from wrapping for any 32-bit address.
  localparam logic [33:0] LIMIT = 34'(RAM_SIZE) * 34'(WORD_STRIDE);

  logic [33:0] w_span;
  logic [33:0] w_src_end;
  logic [33:0] w_dst_end;
  logic        w_src_ok;
  logic        w_dst_ok;

  assign w_span    = 34'(i_word_count) * 34'(WORD_STRIDE);
  assign w_src_end = {2'b00, i_src_addr} + w_span;
  assign w_dst_end = {2'b00, i_dst_addr} + w_span;

  assign w_src_ok = (i_src_addr[1:0] == 2'b00) && (w_src_end <= LIMIT);
  assign w_dst_ok = (i_dst_addr[1:0] == 2'b00) && (w_dst_end <= LIMIT);

  assign o_valid = w_dst_ok && (!i_check_src || w_src_ok);

endmodule

// File: rtl/mem_copy_engine.sv
// Word-at-a-time forward memory copy engine (READ/WRITE per word).
// Optional fill mode is compiled in with the DMA_FILL_EN macro.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int RAM_SIZE     = DEF_RAM_SIZE,
  parameter int RAM_SIZE_BIT = DEF_RAM_SIZE_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [RAM_SIZE_BIT:0] word_count,
`ifdef DMA_FILL_EN
  input  logic                  fill_mode,
  input  logic [31:0]           fill_value,
`endif
  input  logic [31:0]           Read_data,
  output logic [31:0]           Address,
  output logic [31:0]           Write_data,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            dbg_state
);

  localparam logic [RAM_SIZE_BIT:0] CNT_ONE = {{RAM_SIZE_BIT{1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [31:0]           r_src;
  logic [31:0]           r_dst;
  logic [RAM_SIZE_BIT:0] r_count;
  logic [31:0]           r_buf;
  logic                  r_err;
  logic                  w_valid;
  logic                  w_check_src;
  logic [31:0]           w_wdata;
  logic [1:0]            w_first_state;

`ifdef DMA_FILL_EN
  logic                  r_fill;
  logic [31:0]           r_fill_value;

  // Fill transfers never read, so the source pointer is not validated.
  assign w_check_src   = !fill_mode;
  assign w_wdata       = r_fill ? r_fill_value : r_buf;
  assign w_first_state = fill_mode ? ST_WRITE : ST_READ;
`else
  assign w_check_src   = 1'b1;
  assign w_wdata       = r_buf;
  assign w_first_state = ST_READ;
`endif

  mem_copy_range_check #(
    .RAM_SIZE     (RAM_SIZE),
    .RAM_SIZE_BIT (RAM_SIZE_BIT)
  ) u_range_check (
    .i_src_addr   (src_addr),
    .i_dst_addr   (dst_addr),
    .i_word_count (word_count),
    .i_check_src  (w_check_src),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_buf   <= '0;
      r_err   <= 1'b0;
`ifdef DMA_FILL_EN
      r_fill       <= 1'b0;
      r_fill_value <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src   <= src_addr;
            r_dst   <= dst_addr;
            r_count <= word_count;
            r_err   <= !w_valid;
`ifdef DMA_FILL_EN
            r_fill       <= fill_mode;
            r_fill_value <= fill_value;
`endif
            if (!w_valid || (word_count == '0)) begin
              r_state <= ST_FINISH;
            end else begin
              r_state <= w_first_state;
            end
          end
        end
        ST_READ: begin
          r_buf   <= Read_data;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_src   <= r_src + 32'(WORD_STRIDE);
          r_dst   <= r_dst + 32'(WORD_STRIDE);
          r_count <= r_count - CNT_ONE;
          // r_count still holds the pre-decrement value here.
          if (r_count != CNT_ONE) begin
            r_state <= w_first_state_latched();
          end else begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  function automatic logic [1:0] w_first_state_latched();
`ifdef DMA_FILL_EN
    return r_fill ? ST_WRITE : ST_READ;
`else
    return ST_READ;
`endif
  endfunction

  // Bus outputs decode the registered state, so reset clears them at once.
  always_comb begin
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (r_state)
      ST_READ: begin
        Address = r_src;
        MemRead = 1'b1;
      end
      ST_WRITE: begin
        Address    = r_dst;
        Write_data = w_wdata;
        MemWrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign error     = (r_state == ST_FINISH) && r_err;
  assign dbg_state = r_state;

endmodule
